ppg_beat_detector: RTL and testbench

- Downstream consumer of the MAX30100 sensor interface.
- Takes the stream of raw 16-bit IR photoplethysmogram samples and removes the DC component with an exponential moving average.
- Detects heartbeats with a hysteretic threshold state machine, measures the beat-to-beat interval in samples and converts it to beats per minute with a sequential divider.
- Publishes heart_rate plus valid/lock flags for display and host readout.

---
 rtl/ppg_pkg.sv | 19 +
 rtl/seq_divider_u16.sv | 76 +++++++
 rtl/ppg_beat_detector.sv | 156 +++++++++++++++
 tb/tb_ppg_beat_detector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG signal chain (sensor interface, beat detector, SpO2).
package ppg_pkg;

    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } peak_state_e;

    function automatic int unsigned bpm_numerator(input int unsigned rate_hz);
        return 60 * rate_hz;
    endfunction

    localparam int unsigned SAMPLE_RATE_HZ_DEF = 100;
    localparam int unsigned BPM_NUMERATOR      = bpm_numerator(SAMPLE_RATE_HZ_DEF);
    localparam int          THRESH_DEF         = 64;
    localparam int unsigned MIN_INTERVAL_DEF   = 30;
    localparam int unsigned MAX_INTERVAL_DEF   = 300;

endpackage

// File: rtl/seq_divider_u16.sv
// Restoring 16-bit unsigned divider: one quotient bit per cycle, done pulses 17 cycles after start.
module seq_divider_u16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic [16:0] rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [15:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [16:0] shifted;
    logic [16:0] trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q[15:0], quo_q[15]};
        trial   = shifted - {1'b0, dvs_q};
        if (start && !busy_q) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = 5'd16;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // trial borrows out into bit 16 when the divisor does not fit; divisor 0 always fits
            if (!trial[16]) begin
                rem_d = trial;
                quo_d = {quo_q[14:0], 1'b1};
            end else begin
                rem_d = shifted;
                quo_d = {quo_q[14:0], 1'b0};
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/ppg_beat_detector.sv
// PPG beat detector: EMA DC removal, hysteretic peak FSM, interval counter and BPM division.
module ppg_beat_detector
    import ppg_pkg::*;
#(
    parameter int          DATA_W         = 16,
    parameter int unsigned SAMPLE_RATE_HZ = SAMPLE_RATE_HZ_DEF,
    parameter int unsigned DC_SHIFT       = 4,
    parameter int          THRESH         = THRESH_DEF,
    parameter int unsigned MIN_INTERVAL   = MIN_INTERVAL_DEF,
    parameter int unsigned MAX_INTERVAL   = MAX_INTERVAL_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        ir_sample,
    output logic signed [DATA_W:0]   ac_out,
    output logic                     beat,
    output logic [15:0]              heart_rate,
    output logic                     hr_valid,
    output logic                     locked
);

    localparam int unsigned              CNT_W   = $clog2(MAX_INTERVAL + 1);
    localparam logic [CNT_W-1:0]         CNT_MAX = CNT_W'(MAX_INTERVAL);
    localparam logic [CNT_W-1:0]         CNT_MIN = CNT_W'(MIN_INTERVAL);
    localparam logic signed [DATA_W:0]   THR_HI  = (DATA_W + 1)'(THRESH);
    localparam logic signed [DATA_W:0]   THR_LO  = (DATA_W + 1)'(THRESH / 2);
    localparam logic [15:0]              NUMER   = 16'(bpm_numerator(SAMPLE_RATE_HZ));

    logic                   first_q, first_d;
    logic [DATA_W-1:0]      dc_q, dc_d;
    logic signed [DATA_W:0] ac_q, ac_d;
    logic                   ac_vld_q, ac_vld_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    peak_state_e            state_q, state_d;
    logic                   armed_q, armed_d;
    logic                   locked_q, locked_d;
    logic                   beat_q, beat_d;
    logic [15:0]            hr_q, hr_d;
    logic                   hr_valid_q, hr_valid_d;

    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] dc_sum;
    logic                   div_start;
    logic                   div_busy;
    logic                   div_done;
    logic [15:0]            div_quo;

    always_comb begin
        first_d    = first_q;
        dc_d       = dc_q;
        ac_d       = ac_q;
        ac_vld_d   = 1'b0;
        cnt_d      = cnt_q;
        state_d    = state_q;
        armed_d    = armed_q;
        locked_d   = locked_q;
        beat_d     = 1'b0;
        hr_d       = hr_q;
        hr_valid_d = 1'b0;
        div_start  = 1'b0;
        diff       = $signed({1'b0, ir_sample}) - $signed({1'b0, dc_q});
        dc_sum     = $signed({1'b0, dc_q}) + (diff >>> DC_SHIFT);

        if (sample_valid) begin
            ac_vld_d = 1'b1;
            if (!first_q) begin
                first_d = 1'b1;
                dc_d    = ir_sample;
                ac_d    = '0;
            end else begin
                ac_d = diff;
                dc_d = dc_sum[DATA_W-1:0];
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CNT_MAX) begin
                locked_d = 1'b0;
                armed_d  = 1'b0;
            end
        end

        // The FSM acts on the registered ac value, one cycle after the sample strobe
        if (ac_vld_q) begin
            if (state_q == BELOW) begin
                if (ac_q > THR_HI) begin
                    state_d = ABOVE;
                end
            end else if (ac_q < THR_LO) begin
                state_d = BELOW;
                if (cnt_q >= CNT_MIN) begin
                    beat_d = 1'b1;
                    cnt_d  = '0;
                    if (!armed_q || cnt_q == CNT_MAX) begin
                        armed_d = 1'b1;
                    end else if (!div_busy) begin
                        div_start = 1'b1;
                    end
                end
            end
        end

        if (div_done) begin
            hr_d       = div_quo;
            hr_valid_d = 1'b1;
            locked_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q    <= 1'b0;
            dc_q       <= '0;
            ac_q       <= '0;
            ac_vld_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= BELOW;
            armed_q    <= 1'b0;
            locked_q   <= 1'b0;
            beat_q     <= 1'b0;
            hr_q       <= '0;
            hr_valid_q <= 1'b0;
        end else begin
            first_q    <= first_d;
            dc_q       <= dc_d;
            ac_q       <= ac_d;
            ac_vld_q   <= ac_vld_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            armed_q    <= armed_d;
            locked_q   <= locked_d;
            beat_q     <= beat_d;
            hr_q       <= hr_d;
            hr_valid_q <= hr_valid_d;
        end
    end

    seq_divider_u16 u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (NUMER),
        .divisor  (16'(cnt_q)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign ac_out     = ac_q;
    assign beat       = beat_q;
    assign heart_rate = hr_q;
    assign hr_valid   = hr_valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_ppg_beat_detector.sv
// Directed and randomized pulse trains against an arithmetic reference model of the beat detector.
module tb_ppg_beat_detector;

    localparam int BASE = 20000;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_valid = 1'b0;
    logic [15:0]        ir_sample = '0;
    logic signed [16:0] ac_out;
    logic               beat;
    logic [15:0]        heart_rate;
    logic               hr_valid;
    logic               locked;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_first, m_above, m_armed, m_locked, m_beat, m_div, m_pend;
    int m_dc, m_ac, m_cnt, m_hr, m_bpm;
    int hrv_seen;
    int hrv_mark;
    logic last_beat;

    ppg_beat_detector #(
        .DATA_W         (16),
        .SAMPLE_RATE_HZ (100),
        .DC_SHIFT       (4),
        .THRESH         (64),
        .MIN_INTERVAL   (30),
        .MAX_INTERVAL   (300)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .ir_sample    (ir_sample),
        .ac_out       (ac_out),
        .beat         (beat),
        .heart_rate   (heart_rate),
        .hr_valid     (hr_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task model_reset();
        m_first = 0; m_above = 0; m_armed = 0; m_locked = 0;
        m_beat = 0; m_div = 0; m_pend = 0;
        m_dc = 0; m_ac = 0; m_cnt = 0; m_hr = 0; m_bpm = 0;
    endtask

    task model_sample(input int v);
        int d, step, ivl;
        if (!m_first) begin
            m_first = 1;
            m_dc = v;
            m_ac = 0;
        end else begin
            d = v - m_dc;
            m_ac = d;
            step = (d >= 0) ? d / 16 : -((-d + 15) / 16);
            m_dc = m_dc + step;
        end
        if (m_cnt < 300) m_cnt++;
        if (m_cnt == 300) begin
            m_locked = 0;
            m_armed = 0;
        end
        m_beat = 0;
        m_div = 0;
        if (!m_above) begin
            if (m_ac > 64) m_above = 1;
        end else if (m_ac < 32) begin
            m_above = 0;
            if (m_cnt >= 30) begin
                m_beat = 1;
                ivl = m_cnt;
                m_cnt = 0;
                if (!m_armed || ivl >= 300) m_armed = 1;
                else begin
                    m_div = 1;
                    m_bpm = 6000 / ivl;
                end
            end
        end
    endtask

    task drive_and_check(input int v);
        ir_sample = 16'(v);
        sample_valid = 1'b1;
        model_sample(v);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("ac_out", 32'(ac_out), 32'(m_ac));
        chk("beat_early", 32'(beat), 32'd0);
        @(posedge clk); #1;
        chk("beat", 32'(beat), 32'(m_beat));
        last_beat = beat;
        if (m_div) m_pend = 1;
    endtask

    task watch_window(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (m_pend && k == 17) begin
                chk("hr_valid_pulse", 32'(hr_valid), 32'd1);
                chk("heart_rate_new", 32'(heart_rate), 32'(m_bpm));
                m_hr = m_bpm;
                m_locked = 1;
                m_pend = 0;
            end else begin
                chk("hr_valid_idle", 32'(hr_valid), 32'd0);
            end
            if (hr_valid) hrv_seen++;
        end
        chk("heart_rate", 32'(heart_rate), 32'(m_hr));
        chk("locked", 32'(locked), 32'(m_locked));
    endtask

    task send_sample(input int v);
        drive_and_check(v);
        watch_window(18);
    endtask

    task pulse_train(input int period, input int count, input int amp, input int width, input bit noise);
        int v;
        for (int p = 0; p < count; p++) begin
            for (int n = 0; n < period; n++) begin
                v = BASE + ((n < width) ? amp : 0);
                if (noise) v = v + int'($urandom_range(0, 8)) - 4;
                send_sample(v);
            end
        end
    endtask

    initial begin
        model_reset();
        hrv_seen = 0;
        last_beat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ac_out", 32'(ac_out), 32'd0);
        chk("rst_heart_rate", 32'(heart_rate), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_hr_valid", 32'(hr_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // flat input: no AC, no beats, never locks
        for (int i = 0; i < 400; i++) send_sample(BASE);
        chk("flat_locked", 32'(locked), 32'd0);
        chk("flat_hr", 32'(heart_rate), 32'd0);
        chk("flat_hrv", 32'(hrv_seen), 32'd0);

        pulse_train(75, 6, 400, 10, 1'b0);
        chk("p75_hr", 32'(heart_rate), 32'd80);
        chk("p75_locked", 32'(locked), 32'd1);

        pulse_train(60, 4, 400, 10, 1'b0);
        chk("p60_hr", 32'(heart_rate), 32'd100);
        pulse_train(70, 4, 400, 10, 1'b0);
        chk("p70_hr", 32'(heart_rate), 32'd85);

        // refractory: extra pulse ends 20 samples after an accepted beat
        pulse_train(75, 2, 400, 10, 1'b0);
        for (int n = 0; n < 75; n++) begin
            send_sample(BASE + (((n < 10) || (n >= 26 && n < 30)) ? 400 : 0));
            if (n == 30) chk("extra_no_beat", 32'(last_beat), 32'd0);
        end
        pulse_train(75, 1, 400, 10, 1'b0);
        chk("after_extra_hr", 32'(heart_rate), 32'd80);

        // timeout, then re-arm
        for (int i = 0; i < 310; i++) send_sample(BASE);
        chk("timeout_locked", 32'(locked), 32'd0);
        chk("timeout_hr_hold", 32'(heart_rate), 32'd80);
        hrv_mark = hrv_seen;
        pulse_train(90, 1, 400, 10, 1'b0);
        chk("rearm_no_hrv", 32'(hrv_seen - hrv_mark), 32'd0);
        pulse_train(90, 1, 400, 10, 1'b0);
        chk("rearm_hr", 32'(heart_rate), 32'd66);
        chk("rearm_locked", 32'(locked), 32'd1);

        for (int t = 0; t < 4; t++) begin
            pulse_train(int'($urandom_range(40, 120)), 2, int'($urandom_range(150, 600)),
                        int'($urandom_range(4, 12)), 1'b1);
        end

        // reset in the middle of a divide
        pulse_train(80, 3, 400, 10, 1'b0);
        for (int i = 0; i < 10; i++) send_sample(BASE + 400);
        drive_and_check(BASE);
        chk("abort_beat", 32'(beat), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ac_out", 32'(ac_out), 32'd0);
        chk("abort_beat_clr", 32'(beat), 32'd0);
        chk("abort_hr", 32'(heart_rate), 32'd0);
        chk("abort_hr_valid", 32'(hr_valid), 32'd0);
        chk("abort_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            chk("abort_no_hrv", 32'(hr_valid), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        send_sample(BASE + 123);
        chk("reload_first_ac", 32'(ac_out), 32'd0);
        send_sample(BASE + 100);
        chk("reload_dc", 32'(ac_out), -32'sd23);
        for (int i = 0; i < 20; i++) send_sample(BASE + 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
